// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM state encodings and LW mode codes.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_HOLD = 2'd2
  } mem_state_e;

  localparam logic [1:0] LW_FULL  = 2'b11;
  localparam logic [1:0] LW_LEFT  = 2'b10;
  localparam logic [1:0] LW_RIGHT = 2'b01;

endpackage

// File: rtl/Load_sel.sv
// Load data alignment: picks/extends bytes and halves, and builds LWL/LWR merge data and byte masks.
module Load_sel
  import memory_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic        LB,
  input  logic        LBU,
  input  logic        LH,
  input  logic        LHU,
  input  logic [1:0]  LW,
  input  logic [3:0]  RegWrite_in,
  output logic [31:0] data,
  output logic [3:0]  RegWrite
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rdata[{offset, 3'b000} +: 8];
    half_v   = offset[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    RegWrite = RegWrite_in;
    if (LB)       data = {{24{byte_v[7]}}, byte_v};
    else if (LBU) data = {24'd0, byte_v};
    else if (LH)  data = {{16{half_v[15]}}, half_v};
    else if (LHU) data = {16'd0, half_v};
    else begin
      case (LW)
        // LWL fills the upper bytes, LWR the lower ones; WB merges via the mask
        LW_LEFT: begin
          data     = rdata << {~offset, 3'b000};
          RegWrite = 4'b1111 << ~offset;
        end
        LW_RIGHT: begin
          data     = rdata >> {offset, 3'b000};
          RegWrite = 4'b1111 >> offset;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-bus requests, waits/buffers responses, aligns loads, feeds MEM/WB.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_EXE_MEM,
  input  logic        MemEn_EXE_MEM,
  input  logic        MemToReg_EXE_MEM,
  input  logic        mfc0_EXE_MEM,
  input  logic [3:0]  MemWrite_EXE_MEM,
  input  logic [3:0]  RegWrite_EXE_MEM,
  input  logic        LB_EXE_MEM,
  input  logic        LBU_EXE_MEM,
  input  logic        LH_EXE_MEM,
  input  logic        LHU_EXE_MEM,
  input  logic [1:0]  LW_EXE_MEM,
  input  logic [1:0]  MULT_EXE_MEM,
  input  logic [1:0]  MFHL_EXE_MEM,
  input  logic [1:0]  MTHL_EXE_MEM,
  input  logic [4:0]  RegWaddr_EXE_MEM,
  input  logic [31:0] ALUResult_EXE_MEM,
  input  logic [31:0] MemWdata_EXE_MEM,
  input  logic [31:0] PC_EXE_MEM,
  input  logic [31:0] RegRdata1_EXE_MEM,
  input  logic [31:0] RegRdata2_EXE_MEM,
  input  logic [31:0] cp0Rdata_EXE_MEM,
  input  logic        flush,
  input  logic        WB_allowin,
  output logic        MEM_allowin,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        valid_MEM_WB,
  output logic [3:0]  RegWrite_MEM_WB,
  output logic [4:0]  RegWaddr_MEM_WB,
  output logic [31:0] RegWdata_MEM_WB,
  output logic [31:0] PC_MEM_WB,
  output logic [31:0] RegRdata1_MEM_WB,
  output logic [31:0] RegRdata2_MEM_WB,
  output logic [1:0]  MULT_MEM_WB,
  output logic [1:0]  MFHL_MEM_WB,
  output logic [1:0]  MTHL_MEM_WB,
  output logic [31:0] Bypass_MEM
);

  mem_state_e  state, state_nx;
  logic        flush_q;
  logic [31:0] rbuf;
  logic        done, drop, use_buf, fire, cap;
  logic [31:0] ld_data, alu_val, wb_data;
  logic [3:0]  ld_we, wb_we;

  assign data_addr  = {ALUResult_EXE_MEM[31:2], 2'b00};
  assign data_wr    = |MemWrite_EXE_MEM;
  assign data_wstrb = MemWrite_EXE_MEM;
  assign data_wdata = MemWdata_EXE_MEM;

  always_comb begin
    state_nx = state;
    data_req = 1'b0;
    done     = 1'b0;
    drop     = 1'b0;
    use_buf  = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (valid_EXE_MEM && flush) drop = 1'b1;
        else if (valid_EXE_MEM && !MemEn_EXE_MEM) done = 1'b1;
        else if (valid_EXE_MEM) begin
          data_req = rst;
          if (data_addr_ok) begin
            if (data_data_ok) begin
              done = 1'b1;
              if (!WB_allowin) state_nx = MEM_HOLD;
            end else state_nx = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (data_data_ok) begin
          state_nx = MEM_IDLE;
          // a flushed access still owns the bus until its response drains
          if (flush_q || flush) drop = 1'b1;
          else begin
            done = 1'b1;
            if (!WB_allowin) state_nx = MEM_HOLD;
          end
        end
      end
      MEM_HOLD: begin
        if (flush) begin
          drop     = 1'b1;
          state_nx = MEM_IDLE;
        end else begin
          done    = 1'b1;
          use_buf = 1'b1;
          if (WB_allowin) state_nx = MEM_IDLE;
        end
      end
      default: state_nx = MEM_IDLE;
    endcase
  end

  assign fire        = done & WB_allowin;
  assign cap         = (state_nx == MEM_HOLD) && (state != MEM_HOLD);
  assign MEM_allowin = ~valid_EXE_MEM | fire | drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= MEM_IDLE;
      flush_q <= 1'b0;
      rbuf    <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == MEM_WAIT) flush_q <= data_data_ok ? 1'b0 : (flush_q | flush);
      else                   flush_q <= 1'b0;
      if (cap) rbuf <= data_rdata;
    end
  end

  Load_sel u_load_sel (
    .rdata       (use_buf ? rbuf : data_rdata),
    .offset      (ALUResult_EXE_MEM[1:0]),
    .LB          (LB_EXE_MEM),
    .LBU         (LBU_EXE_MEM),
    .LH          (LH_EXE_MEM),
    .LHU         (LHU_EXE_MEM),
    .LW          (LW_EXE_MEM),
    .RegWrite_in (RegWrite_EXE_MEM),
    .data        (ld_data),
    .RegWrite    (ld_we)
  );

  assign alu_val    = mfc0_EXE_MEM ? cp0Rdata_EXE_MEM : ALUResult_EXE_MEM;
  assign wb_data    = MemToReg_EXE_MEM ? ld_data : alu_val;
  assign wb_we      = MemToReg_EXE_MEM ? ld_we : RegWrite_EXE_MEM;
  assign Bypass_MEM = done ? wb_data : alu_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_MEM_WB     <= 1'b0;
      RegWrite_MEM_WB  <= 4'd0;
      RegWaddr_MEM_WB  <= 5'd0;
      RegWdata_MEM_WB  <= 32'd0;
      PC_MEM_WB        <= 32'd0;
      RegRdata1_MEM_WB <= 32'd0;
      RegRdata2_MEM_WB <= 32'd0;
      MULT_MEM_WB      <= 2'd0;
      MFHL_MEM_WB      <= 2'd0;
      MTHL_MEM_WB      <= 2'd0;
    end else if (WB_allowin) begin
      valid_MEM_WB <= fire;
      if (fire) begin
        RegWrite_MEM_WB  <= wb_we;
        RegWaddr_MEM_WB  <= RegWaddr_EXE_MEM;
        RegWdata_MEM_WB  <= wb_data;
        PC_MEM_WB        <= PC_EXE_MEM;
        RegRdata1_MEM_WB <= RegRdata1_EXE_MEM;
        RegRdata2_MEM_WB <= RegRdata2_EXE_MEM;
        MULT_MEM_WB      <= MULT_EXE_MEM;
        MFHL_MEM_WB      <= MFHL_EXE_MEM;
        MTHL_MEM_WB      <= MTHL_EXE_MEM;
      end else begin
        RegWrite_MEM_WB <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus multi-cycle wait/hold/flush/reset sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid, memen, memtoreg, mfc0, lb, lbu, lh, lhu, flush, wb_allowin;
  logic [3:0]  mw, rw;
  logic [1:0]  lw, mult, mfhl, mthl;
  logic [4:0]  waddr;
  logic [31:0] alu, wdata, pc, rd1, rd2, cp0, rdata;
  logic        addr_ok, data_ok;

  logic        MEM_allowin, data_req, data_wr, valid_MEM_WB;
  logic [3:0]  data_wstrb, RegWrite_MEM_WB;
  logic [31:0] data_addr, data_wdata, RegWdata_MEM_WB, PC_MEM_WB, RegRdata1_MEM_WB;
  logic [31:0] RegRdata2_MEM_WB, Bypass_MEM;
  logic [4:0]  RegWaddr_MEM_WB;
  logic [1:0]  MULT_MEM_WB, MFHL_MEM_WB, MTHL_MEM_WB;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .valid_EXE_MEM(valid), .MemEn_EXE_MEM(memen),
    .MemToReg_EXE_MEM(memtoreg), .mfc0_EXE_MEM(mfc0), .MemWrite_EXE_MEM(mw),
    .RegWrite_EXE_MEM(rw), .LB_EXE_MEM(lb), .LBU_EXE_MEM(lbu), .LH_EXE_MEM(lh),
    .LHU_EXE_MEM(lhu), .LW_EXE_MEM(lw), .MULT_EXE_MEM(mult), .MFHL_EXE_MEM(mfhl),
    .MTHL_EXE_MEM(mthl), .RegWaddr_EXE_MEM(waddr), .ALUResult_EXE_MEM(alu),
    .MemWdata_EXE_MEM(wdata), .PC_EXE_MEM(pc), .RegRdata1_EXE_MEM(rd1),
    .RegRdata2_EXE_MEM(rd2), .cp0Rdata_EXE_MEM(cp0), .flush(flush),
    .WB_allowin(wb_allowin), .MEM_allowin(MEM_allowin), .data_req(data_req),
    .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(addr_ok), .data_data_ok(data_ok),
    .data_rdata(rdata), .valid_MEM_WB(valid_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
    .RegWaddr_MEM_WB(RegWaddr_MEM_WB), .RegWdata_MEM_WB(RegWdata_MEM_WB),
    .PC_MEM_WB(PC_MEM_WB), .RegRdata1_MEM_WB(RegRdata1_MEM_WB),
    .RegRdata2_MEM_WB(RegRdata2_MEM_WB), .MULT_MEM_WB(MULT_MEM_WB),
    .MFHL_MEM_WB(MFHL_MEM_WB), .MTHL_MEM_WB(MTHL_MEM_WB), .Bypass_MEM(Bypass_MEM)
  );

  typedef struct {
    string       name;
    logic        memen, memtoreg, mfc0, lb, lbu, lh, lhu;
    logic [1:0]  lw;
    logic [3:0]  mw, rw;
    logic [31:0] alu, cp0, rdata, wdata;
    logic [31:0] e_addr;
    logic [3:0]  e_rw;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    valid = 0; memen = 0; memtoreg = 0; mfc0 = 0; lb = 0; lbu = 0; lh = 0; lhu = 0;
    lw = 0; mw = 0; rw = 0; mult = 0; mfhl = 0; mthl = 0; waddr = 0;
    alu = 0; wdata = 0; pc = 0; rd1 = 0; rd2 = 0; cp0 = 0; rdata = 0;
    addr_ok = 0; data_ok = 0; flush = 0; wb_allowin = 1;
  endtask

  function automatic vec_t mk(input string nm, input logic [6:0] f, input logic [1:0] l,
                              input logic [3:0] m, input logic [3:0] r, input logic [31:0] a,
                              input logic [31:0] c, input logic [31:0] rd, input logic [31:0] wd,
                              input logic [31:0] ea, input logic [3:0] er, input logic [31:0] ed);
    vec_t v;
    v.name = nm;
    {v.memen, v.memtoreg, v.mfc0, v.lb, v.lbu, v.lh, v.lhu} = f;
    v.lw = l; v.mw = m; v.rw = r; v.alu = a; v.cp0 = c; v.rdata = rd; v.wdata = wd;
    v.e_addr = ea; v.e_rw = er; v.e_data = ed;
    return v;
  endfunction

  // nonmem ADD, LW pre-set in the issue phase of each sequence
  task automatic issue_add(input logic [31:0] val);
    clr(); valid = 1; rw = 4'b1111; alu = val;
  endtask

  task automatic issue_lw(input logic [31:0] a);
    clr(); valid = 1; memen = 1; memtoreg = 1; lw = 2'b11; rw = 4'b1111; alu = a;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    //             name    {memen,m2r,mfc0,lb,lbu,lh,lhu} lw  mw  rw  alu  cp0  rdata  wdata  e_addr  e_rw  e_data
    vt[0]  = mk("add",   7'b0000000, 2'b00, 4'b0000, 4'b1111, 32'h1234_5678, 0, 0, 0, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    vt[1]  = mk("mfc0",  7'b0010000, 2'b00, 4'b0000, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
    vt[2]  = mk("lb3",   7'b1101000, 2'b00, 4'b0000, 4'b1111, 32'h1000_0003, 0, 32'h80FF_1234, 0, 32'h1000_0000, 4'b1111, 32'hFFFF_FF80);
    vt[3]  = mk("lbu3",  7'b1100100, 2'b00, 4'b0000, 4'b1111, 32'h1000_0003, 0, 32'h80FF_1234, 0, 32'h1000_0000, 4'b1111, 32'h0000_0080);
    vt[4]  = mk("lb0",   7'b1101000, 2'b00, 4'b0000, 4'b1111, 32'h1000_0000, 0, 32'h80FF_1234, 0, 32'h1000_0000, 4'b1111, 32'h0000_0034);
    vt[5]  = mk("lb2",   7'b1101000, 2'b00, 4'b0000, 4'b1111, 32'h1000_0002, 0, 32'h80FF_1234, 0, 32'h1000_0000, 4'b1111, 32'hFFFF_FFFF);
    vt[6]  = mk("lh2",   7'b1100010, 2'b00, 4'b0000, 4'b1111, 32'h1000_0002, 0, 32'h80FF_1234, 0, 32'h1000_0000, 4'b1111, 32'hFFFF_80FF);
    vt[7]  = mk("lhu0",  7'b1100001, 2'b00, 4'b0000, 4'b1111, 32'h1000_0000, 0, 32'h80FF_1234, 0, 32'h1000_0000, 4'b1111, 32'h0000_1234);
    vt[8]  = mk("lhu2",  7'b1100001, 2'b00, 4'b0000, 4'b1111, 32'h1000_0002, 0, 32'h80FF_1234, 0, 32'h1000_0000, 4'b1111, 32'h0000_80FF);
    vt[9]  = mk("lw",    7'b1100000, 2'b11, 4'b0000, 4'b1111, 32'h1000_0004, 0, 32'h80FF_1234, 0, 32'h1000_0004, 4'b1111, 32'h80FF_1234);
    vt[10] = mk("lwl1",  7'b1100000, 2'b10, 4'b0000, 4'b1111, 32'h1000_0001, 0, 32'hAABB_CCDD, 0, 32'h1000_0000, 4'b1100, 32'hCCDD_0000);
    vt[11] = mk("lwr2",  7'b1100000, 2'b01, 4'b0000, 4'b1111, 32'h1000_0002, 0, 32'hAABB_CCDD, 0, 32'h1000_0000, 4'b0011, 32'h0000_AABB);
    vt[12] = mk("lwl0",  7'b1100000, 2'b10, 4'b0000, 4'b1111, 32'h1000_0000, 0, 32'hAABB_CCDD, 0, 32'h1000_0000, 4'b1000, 32'hDD00_0000);
    vt[13] = mk("lwl3",  7'b1100000, 2'b10, 4'b0000, 4'b1111, 32'h1000_0003, 0, 32'hAABB_CCDD, 0, 32'h1000_0000, 4'b1111, 32'hAABB_CCDD);
    vt[14] = mk("lwr0",  7'b1100000, 2'b01, 4'b0000, 4'b1111, 32'h1000_0000, 0, 32'hAABB_CCDD, 0, 32'h1000_0000, 4'b1111, 32'hAABB_CCDD);
    vt[15] = mk("lwr3",  7'b1100000, 2'b01, 4'b0000, 4'b1111, 32'h1000_0003, 0, 32'hAABB_CCDD, 0, 32'h1000_0000, 4'b0001, 32'h0000_00AA);
    vt[16] = mk("sw",    7'b1000000, 2'b00, 4'b1111, 4'b0000, 32'h2000_0004, 0, 0, 32'h1122_3344, 32'h2000_0004, 4'b0000, 32'h2000_0004);
    vt[17] = mk("sb1",   7'b1000000, 2'b00, 4'b0010, 4'b0000, 32'h2000_0005, 0, 0, 32'h0000_AA00, 32'h2000_0004, 4'b0000, 32'h2000_0005);

    clr();
    #2;
    chk("rst_valid", 32'(valid_MEM_WB), 0);
    chk("rst_rw", 32'(RegWrite_MEM_WB), 0);
    chk("rst_wdata", RegWdata_MEM_WB, 0);
    chk("rst_req", 32'(data_req), 0);
    @(negedge clk); @(negedge clk); rst = 1;

    // single-cycle completions: addr_ok and data_ok together, WB ready
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      clr();
      valid = 1; memen = vt[i].memen; memtoreg = vt[i].memtoreg; mfc0 = vt[i].mfc0;
      lb = vt[i].lb; lbu = vt[i].lbu; lh = vt[i].lh; lhu = vt[i].lhu; lw = vt[i].lw;
      mw = vt[i].mw; rw = vt[i].rw; alu = vt[i].alu; cp0 = vt[i].cp0;
      rdata = vt[i].rdata; wdata = vt[i].wdata;
      addr_ok = vt[i].memen; data_ok = vt[i].memen;
      waddr = 5'(i + 1); pc = 32'h0040_0000 + 32'(i * 4);
      #1;
      chk({vt[i].name, "_req"}, 32'(data_req), 32'(vt[i].memen));
      chk({vt[i].name, "_addr"}, data_addr, vt[i].e_addr);
      chk({vt[i].name, "_wr"}, 32'(data_wr), 32'(|vt[i].mw));
      chk({vt[i].name, "_allowin"}, 32'(MEM_allowin), 1);
      chk({vt[i].name, "_bypass"}, Bypass_MEM, vt[i].e_data);
      if (vt[i].memen && vt[i].mw != 0) begin
        chk({vt[i].name, "_wstrb"}, 32'(data_wstrb), 32'(vt[i].mw));
        chk({vt[i].name, "_wdata"}, data_wdata, vt[i].wdata);
      end
      @(posedge clk); #1;
      chk({vt[i].name, "_wb_valid"}, 32'(valid_MEM_WB), 1);
      chk({vt[i].name, "_wb_rw"}, 32'(RegWrite_MEM_WB), 32'(vt[i].e_rw));
      chk({vt[i].name, "_wb_data"}, RegWdata_MEM_WB, vt[i].e_data);
      chk({vt[i].name, "_wb_waddr"}, 32'(RegWaddr_MEM_WB), 32'(i + 1));
      chk({vt[i].name, "_wb_pc"}, PC_MEM_WB, 32'h0040_0000 + 32'(i * 4));
    end

    // flush in IDLE: no request, dropped, stray responses ignored
    @(negedge clk);
    issue_lw(32'h3000_0000); flush = 1; addr_ok = 1; data_ok = 1;
    #1;
    chk("fidle_req", 32'(data_req), 0);
    chk("fidle_allowin", 32'(MEM_allowin), 1);
    @(posedge clk); #1;
    chk("fidle_wb_valid", 32'(valid_MEM_WB), 0);

    // store: addr_ok cycle 1, data_ok cycle 4
    @(negedge clk);
    clr(); valid = 1; memen = 1; mw = 4'b1111; alu = 32'h0000_0040; wdata = 32'h5566_7788;
    addr_ok = 1;
    #1;
    chk("sw_c1_req", 32'(data_req), 1);
    chk("sw_c1_allowin", 32'(MEM_allowin), 0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk); #1;
      chk("sw_wait_req", 32'(data_req), 0);
      chk("sw_wait_allowin", 32'(MEM_allowin), 0);
      chk("sw_wait_wb_valid", 32'(valid_MEM_WB), 0);
    end
    @(negedge clk);
    addr_ok = 0; data_ok = 1;
    #1;
    chk("sw_c4_req", 32'(data_req), 0);
    chk("sw_c4_allowin", 32'(MEM_allowin), 1);
    @(posedge clk); #1;
    chk("sw_done_valid", 32'(valid_MEM_WB), 1);

    // load with WB stalled: response buffered through HOLD
    @(negedge clk);
    issue_lw(32'h0000_0050); addr_ok = 1;
    @(negedge clk);
    addr_ok = 0; data_ok = 1; rdata = 32'hCAFE_F00D; wb_allowin = 0;
    #1;
    chk("hold_dok_allowin", 32'(MEM_allowin), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      data_ok = 0; rdata = 32'h0BAD_BAD0;
      #1;
      chk("hold_allowin", 32'(MEM_allowin), 0);
      chk("hold_req", 32'(data_req), 0);
      chk("hold_wb_valid", 32'(valid_MEM_WB), 0);
    end
    @(negedge clk);
    wb_allowin = 1;
    #1;
    chk("hold_rel_allowin", 32'(MEM_allowin), 1);
    chk("hold_rel_bypass", Bypass_MEM, 32'hCAFE_F00D);
    @(posedge clk); #1;
    chk("hold_wb_valid_out", 32'(valid_MEM_WB), 1);
    chk("hold_wb_data", RegWdata_MEM_WB, 32'hCAFE_F00D);
    chk("hold_wb_rw", 32'(RegWrite_MEM_WB), 32'hF);

    // flush while waiting: response discarded, next instruction proceeds
    @(negedge clk);
    issue_lw(32'h0000_0060); addr_ok = 1; wb_allowin = 0;
    @(negedge clk);
    addr_ok = 0; flush = 1;
    #1;
    chk("fwait_allowin_a", 32'(MEM_allowin), 0);
    @(negedge clk);
    flush = 0;
    #1;
    chk("fwait_allowin_b", 32'(MEM_allowin), 0);
    chk("fwait_req", 32'(data_req), 0);
    @(negedge clk);
    data_ok = 1; rdata = 32'h1111_1111; wb_allowin = 1;
    #1;
    chk("fwait_dok_allowin", 32'(MEM_allowin), 1);
    @(posedge clk); #1;
    chk("fwait_wb_valid", 32'(valid_MEM_WB), 0);
    chk("fwait_wb_rw", 32'(RegWrite_MEM_WB), 0);
    @(negedge clk);
    issue_add(32'h0000_0055);
    @(posedge clk); #1;
    chk("fwait_next_valid", 32'(valid_MEM_WB), 1);
    chk("fwait_next_data", RegWdata_MEM_WB, 32'h0000_0055);

    // reset during WAIT, then a stray data_ok
    @(negedge clk);
    issue_add(32'h0000_0077);
    @(negedge clk);
    issue_lw(32'h0000_0070); addr_ok = 1; wb_allowin = 0;
    #1;
    chk("rwait_pre_valid", 32'(valid_MEM_WB), 1);
    @(negedge clk);
    addr_ok = 0;
    #1;
    chk("rwait_req", 32'(data_req), 0);
    #1; rst = 0; #1;
    chk("rwait_rst_valid", 32'(valid_MEM_WB), 0);
    chk("rwait_rst_data", RegWdata_MEM_WB, 0);
    chk("rwait_rst_rw", 32'(RegWrite_MEM_WB), 0);
    chk("rwait_rst_req", 32'(data_req), 0);
    @(negedge clk);
    rst = 1; clr(); data_ok = 1; rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    chk("stray_wb_valid", 32'(valid_MEM_WB), 0);
    @(negedge clk);
    issue_add(32'h0000_0099);
    #1;
    chk("stray_req", 32'(data_req), 0);
    chk("stray_allowin", 32'(MEM_allowin), 1);
    @(posedge clk); #1;
    chk("stray_next_valid", 32'(valid_MEM_WB), 1);
    chk("stray_next_data", RegWdata_MEM_WB, 32'h0000_0099);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 valid_EXE_MEM  in  1  EXE/MEM register holds a live instruction.
REQ-004 MemEn_EXE_MEM, MemToReg_EXE_MEM, mfc0_EXE_MEM  in  1 each  memory access, load, MFC0 flags.
REQ-005 MemWrite_EXE_MEM, RegWrite_EXE_MEM  in  4 each  store byte strobes, register byte-write mask.
REQ-006 LB/LBU/LH/LHU_EXE_MEM  in  1 each; LW_EXE_MEM  in  2  (11 LW, 10 LWL, 01 LWR).
REQ-007 MULT/MFHL/MTHL_EXE_MEM  in  2 each; RegWaddr_EXE_MEM  in  5  passthrough controls.
REQ-008 ALUResult, MemWdata, PC, RegRdata1, RegRdata2, cp0Rdata (_EXE_MEM)  in  32 each.
REQ-009 flush  in  1  exception flush of the MEM-stage instruction.
REQ-010 WB_allowin  in  1  WB accepts a new instruction this cycle.
REQ-011 MEM_allowin  out  1  EXE/MEM may load a new instruction.
REQ-012 data_req, data_wr  out  1; data_wstrb  out  4; data_addr, data_wdata  out  32  memory request.
REQ-013 data_addr_ok, data_data_ok  in  1; data_rdata  in  32  memory responses.
REQ-014 valid_MEM_WB  out  1; RegWrite_MEM_WB  out  4; RegWaddr_MEM_WB  out  5; RegWdata_MEM_WB  out  32.
REQ-015 PC, RegRdata1, RegRdata2 (_MEM_WB)  out  32; MULT/MFHL/MTHL_MEM_WB  out  2  passthrough.
REQ-016 Bypass_MEM  out  32  forwarding value of the MEM-stage instruction.

Function
REQ-017 FSM states IDLE, WAIT (address accepted, awaiting data_ok), HOLD (response buffered, WB stalled).
REQ-018 In IDLE with valid, MemEn and no flush: data_req=1, data_addr={ALUResult[31:2],2'b00}, data_wr=|MemWrite, data_wstrb=MemWrite, data_wdata=MemWdata.
REQ-019 IDLE->WAIT on data_addr_ok without data_data_ok; data_addr_ok with data_data_ok in the same cycle completes the access directly.
REQ-020 WAIT ignores data_addr_ok; WAIT->IDLE on data_data_ok with WB_allowin, else WAIT->HOLD with data_rdata captured in an internal buffer.
REQ-021 HOLD->IDLE when WB_allowin; data_req=0 in WAIT and HOLD.
REQ-022 Non-memory instruction completes in its first cycle; RegWdata = mfc0 ? cp0Rdata : ALUResult.
REQ-023 Load data from offset a=ALUResult[1:0]: LB/LBU byte a sign/zero-extended; LH/LHU half a[1]; LW full word.
REQ-024 LWL a=0..3: RegWrite 1000/1100/1110/1111, data rdata<<(8*(3-a)); LWR a=0..3: 1111/0111/0011/0001, data rdata>>(8*a).
REQ-025 Completion with WB_allowin: MEM_WB registers load on that edge, valid_MEM_WB=1; otherwise valid_MEM_WB=0 on next edge when WB_allowin.
REQ-026 MEM_allowin = ~valid_EXE_MEM | (completion & WB_allowin).
REQ-027 flush in IDLE: no request, instruction dropped, MEM_allowin=1, valid_MEM_WB=0.
REQ-028 flush in WAIT: outstanding response still awaited and discarded; RegWrite_MEM_WB=0 for that instruction; flush latched until data_data_ok.
REQ-029 Bypass_MEM = RegWdata value when complete, else ALUResult/cp0Rdata (loads signal not-ready via MemToReg).

Reset
REQ-030 rst low: FSM IDLE, flush latch 0, all MEM_WB outputs 0, data_req 0, immediately and independent of clk.
REQ-031 Reset deasserted mid-access: any late data_data_ok arriving in IDLE is ignored.

Structure
REQ-032 State encodings and LW mode codes (11/10/01) reside in the shared pipeline package.
REQ-033 Load alignment (REQ-023/024) is one combinational sub-module named Load_sel.

Verification
REQ-034 LB, a=3, rdata=0x80FF_1234, addr_ok+data_ok same cycle -> RegWdata=0xFFFF_FF80, RegWrite=1111, one-cycle completion.
REQ-035 LWL a=1, rdata=0xAABB_CCDD -> RegWrite=1100, data[31:16]=0xCCDD; LWR a=2 -> RegWrite=0011, data[15:0]=0xAABB.
REQ-036 SW, addr_ok at cycle 1, data_ok at cycle 4 -> WAIT cycles 2-4, MEM_allowin=0 until cycle 4, data_req=1 only cycle 1.
REQ-037 LW, data_ok while WB_allowin=0 for 3 cycles -> HOLD 3 cycles, buffered rdata delivered unchanged.
REQ-038 flush in WAIT, then data_ok -> valid_MEM_WB=0, RegWrite_MEM_WB=0000, next instruction proceeds.
REQ-039 rst low during WAIT -> outputs 0 immediately; stray data_ok after release produces no writeback.
